line_bus_bridge: RTL and testbench

- Downstream neighbour of the direct-mapped L1 cache. Converts the cache's single-cycle, line-wide memory command interface into a beat-serialised burst bus toward the memory controller.
- Reads: collects BEATS narrow beats into one line, then returns it to the cache with a one-cycle valid pulse.
- Writes (dirty writebacks): streams the latched line out beat by beat, then returns a one-cycle done pulse after the memory write response.

---
 rtl/cache_bus_pkg.sv | 36 +++
 rtl/line_beat_buffer.sv | 43 ++++
 rtl/line_bus_bridge.sv | 162 ++++++++++++++++
 tb/tb_line_bus_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the L1 cache and its line/burst bus bridge:
// state encoding, line geometry helpers and line-address alignment.
package cache_bus_pkg;

    localparam int ADDR_MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WBEAT,
        ST_WRESP,
        ST_RBEAT,
        ST_RESP
    } bus_state_e;

    function automatic int calc_line_bits(input int data_width, input int offset_length);
        return data_width * (2 ** offset_length);
    endfunction

    function automatic int calc_beats(input int line_bits, input int bus_width);
        return line_bits / bus_width;
    endfunction

    function automatic int calc_bcnt_w(input int beats);
        return (beats <= 2) ? 1 : $clog2(beats);
    endfunction

    // Clears the word-offset bits so the address names the start of its line.
    function automatic logic [ADDR_MAX_W-1:0] align_line_addr(
        input logic [ADDR_MAX_W-1:0] addr,
        input int                    offset_length
    );
        return addr & ({ADDR_MAX_W{1'b1}} << offset_length);
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide register addressed in bus beats: beat writes for fills, a beat
// read mux for writeback streaming, and a whole-line load port.
module line_beat_buffer #(
    parameter int LINE_BITS = 1024,
    parameter int BUS_WIDTH = 64,
    parameter int BCNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic [LINE_BITS-1:0] i_line,
    input  logic                 i_wr_en,
    input  logic [BCNT_W-1:0]    i_wr_idx,
    input  logic [BUS_WIDTH-1:0] i_wr_beat,
    input  logic [BCNT_W-1:0]    i_rd_idx,
    output logic [BUS_WIDTH-1:0] o_rd_beat,
    output logic [LINE_BITS-1:0] o_line_merged
);

    logic [LINE_BITS-1:0] r_line;
    logic [LINE_BITS-1:0] w_merged;

    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    always_comb begin
        w_merged = r_line;
        w_merged[int'(i_wr_idx) * BUS_WIDTH +: BUS_WIDTH] = i_wr_beat;
    end

    // NOTE: the line buffer is plain flops, so clearing it on reset is cheap and keeps outputs defined.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_wr_en) begin
            r_line <= w_merged;
        end
    end

    assign o_rd_beat     = r_line[int'(i_rd_idx) * BUS_WIDTH +: BUS_WIDTH];
    assign o_line_merged = w_merged;

endmodule

// File: rtl/line_bus_bridge.sv
// Bridges the cache's single-cycle line command interface to a beat-serialised
// burst bus: fills gather BEATS beats, writebacks stream the latched line out.
module line_bus_bridge
    import cache_bus_pkg::*;
#(
    parameter  int ADDR_WIDTH    = 64,
    parameter  int DATA_WIDTH    = 64,
    parameter  int OFFSET_LENGTH = 4,
    parameter  int BUS_WIDTH     = 64,
    localparam int LINE_BITS     = calc_line_bits(DATA_WIDTH, OFFSET_LENGTH),
    localparam int BEATS         = calc_beats(LINE_BITS, BUS_WIDTH),
    localparam int BCNT_W        = calc_bcnt_w(BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  command_valid,
    input  logic                  command_store,
    input  logic                  command_rready,
    input  logic [ADDR_WIDTH-1:0] command_addr,
    input  logic [LINE_BITS-1:0]  data_to_bus,
    output logic [LINE_BITS-1:0]  data_from_bus,
    output logic                  bus_valid,
    output logic                  bus_ready,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    output logic                  mem_wlast,
    input  logic                  mem_bvalid,
    input  logic                  mem_rvalid,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_rlast,
    output logic                  mem_rready,
    output logic                  err
);

    bus_state_e            r_state;
    bus_state_e            w_state_next;
    logic [BCNT_W-1:0]     r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_store;
    logic                  r_err;
    logic [LINE_BITS-1:0]  r_fill_line;

    logic                  w_last_beat;
    logic                  w_latch_cmd;
    logic                  w_beat_in;
    logic                  w_beat_out;
    logic [ADDR_WIDTH-1:0] w_aligned_addr;
    logic [BUS_WIDTH-1:0]  w_rd_beat;
    logic [LINE_BITS-1:0]  w_merged_line;
    logic                  w_unused;

    // Fills always complete, so the cache's ready only matters to the cache.
    assign w_unused = command_rready;

    assign w_last_beat    = (r_cnt == BCNT_W'(BEATS - 1));
    assign w_latch_cmd    = (r_state == ST_IDLE) && command_valid;
    assign w_beat_in      = (r_state == ST_RBEAT) && mem_rvalid;
    assign w_beat_out     = (r_state == ST_WBEAT) && mem_wready;
    assign w_aligned_addr = ADDR_WIDTH'(align_line_addr(ADDR_MAX_W'(command_addr), OFFSET_LENGTH));

    line_beat_buffer #(
        .LINE_BITS (LINE_BITS),
        .BUS_WIDTH (BUS_WIDTH),
        .BCNT_W    (BCNT_W)
    ) u_line_buf (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_latch_cmd && command_store),
        .i_line        (data_to_bus),
        .i_wr_en       (w_beat_in),
        .i_wr_idx      (r_cnt),
        .i_wr_beat     (mem_rdata),
        .i_rd_idx      (r_cnt),
        .o_rd_beat     (w_rd_beat),
        .o_line_merged (w_merged_line)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        mem_req_valid = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        mem_wlast     = 1'b0;
        mem_rready    = 1'b0;
        bus_valid     = 1'b0;
        bus_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (command_valid) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) w_state_next = r_store ? ST_WBEAT : ST_RBEAT;
            end
            ST_WBEAT: begin
                mem_wvalid = 1'b1;
                mem_wdata  = w_rd_beat;
                mem_wlast  = w_last_beat;
                if (mem_wready && w_last_beat) w_state_next = ST_WRESP;
            end
            ST_WRESP: begin
                if (mem_bvalid) w_state_next = ST_RESP;
            end
            ST_RBEAT: begin
                mem_rready = 1'b1;
                if (mem_rvalid && w_last_beat) w_state_next = ST_RESP;
            end
            ST_RESP: begin
                bus_valid    = !r_store;
                bus_ready    = r_store;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The fill result lives apart from the beat buffer so a later writeback
    // load cannot disturb the line the cache last received.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_store     <= 1'b0;
            r_err       <= 1'b0;
            r_fill_line <= '0;
        end else begin
            if (w_latch_cmd) begin
                r_addr  <= w_aligned_addr;
                r_store <= command_store;
            end
            if (w_beat_in || w_beat_out) begin
                r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            end
            if (w_beat_in && (mem_rlast != w_last_beat)) begin
                r_err <= 1'b1;
            end
            if (w_beat_in && w_last_beat) begin
                r_fill_line <= w_merged_line;
            end
        end
    end

    assign data_from_bus = r_fill_line;
    assign mem_req_addr  = r_addr;
    assign mem_req_write = r_store;
    assign err           = r_err;

endmodule

// File: tb/tb_line_bus_bridge.sv
// Self-checking bench for line_bus_bridge: directed scenarios plus randomized
// transactions compared against a line/beat reference model.
module tb_line_bus_bridge;

    localparam int ADDR_WIDTH    = 64;
    localparam int DATA_WIDTH    = 64;
    localparam int OFFSET_LENGTH = 4;
    localparam int BUS_WIDTH     = 64;
    localparam int LINE_BITS     = DATA_WIDTH * (2 ** OFFSET_LENGTH);
    localparam int BEATS         = LINE_BITS / BUS_WIDTH;
    localparam int WORDS         = 2 ** OFFSET_LENGTH;

    logic                  clk;
    logic                  reset;
    logic                  command_valid;
    logic                  command_store;
    logic                  command_rready;
    logic [ADDR_WIDTH-1:0] command_addr;
    logic [LINE_BITS-1:0]  data_to_bus;
    logic [LINE_BITS-1:0]  data_from_bus;
    logic                  bus_valid;
    logic                  bus_ready;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_wvalid;
    logic                  mem_wready;
    logic [BUS_WIDTH-1:0]  mem_wdata;
    logic                  mem_wlast;
    logic                  mem_bvalid;
    logic                  mem_rvalid;
    logic [BUS_WIDTH-1:0]  mem_rdata;
    logic                  mem_rlast;
    logic                  mem_rready;
    logic                  err;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [BUS_WIDTH-1:0]  beat_mem [BEATS];
    logic [LINE_BITS-1:0]  exp_fill;
    logic                  exp_err;

    line_bus_bridge #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .OFFSET_LENGTH (OFFSET_LENGTH),
        .BUS_WIDTH     (BUS_WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .command_valid  (command_valid),
        .command_store  (command_store),
        .command_rready (command_rready),
        .command_addr   (command_addr),
        .data_to_bus    (data_to_bus),
        .data_from_bus  (data_from_bus),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_wvalid     (mem_wvalid),
        .mem_wready     (mem_wready),
        .mem_wdata      (mem_wdata),
        .mem_wlast      (mem_wlast),
        .mem_bvalid     (mem_bvalid),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_rlast      (mem_rlast),
        .mem_rready     (mem_rready),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] a);
        return a & ~((ADDR_WIDTH'(1) << OFFSET_LENGTH) - 1);
    endfunction

    function automatic logic [LINE_BITS-1:0] line_from_beats();
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < BEATS; i++) l[i*BUS_WIDTH +: BUS_WIDTH] = beat_mem[i];
        return l;
    endfunction

    task automatic check_line(input string tag, input logic [LINE_BITS-1:0] exp);
        for (int i = 0; i < WORDS; i++)
            check($sformatf("%s_w%0d", tag, i), data_from_bus[i*DATA_WIDTH +: DATA_WIDTH],
                  exp[i*DATA_WIDTH +: DATA_WIDTH]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_valid"}, bus_valid, 0);
        check({tag, "_bus_ready"}, bus_ready, 0);
        check({tag, "_req_valid"}, mem_req_valid, 0);
        check({tag, "_req_write"}, mem_req_write, 0);
        check({tag, "_req_addr"}, mem_req_addr, 0);
        check({tag, "_wvalid"}, mem_wvalid, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_wlast"}, mem_wlast, 0);
        check({tag, "_rready"}, mem_rready, 0);
        check({tag, "_err"}, err, 0);
        check_line({tag, "_line"}, '0);
    endtask

    task automatic send_cmd(input logic store, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [LINE_BITS-1:0] line, input bit keep);
        command_valid = 1'b1;
        command_store = store;
        command_addr  = addr;
        data_to_bus   = line;
        tick();
        if (!keep) command_valid = 1'b0;
        if (!keep) data_to_bus = {WORDS{rand64()}};
    endtask

    task automatic req_phase(input logic [ADDR_WIDTH-1:0] exp_addr, input logic exp_write,
                             input int hold);
        for (int h = 0; h < hold; h++) begin
            mem_req_ready = 1'b0;
            check("req_hold_valid", mem_req_valid, 1);
            check("req_hold_addr", mem_req_addr, exp_addr);
            check("req_hold_write", mem_req_write, exp_write);
            check("req_hold_wvalid", mem_wvalid, 0);
            check("req_hold_rready", mem_rready, 0);
            tick();
        end
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_req_addr, exp_addr);
        check("req_write", mem_req_write, exp_write);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("req_dropped", mem_req_valid, 0);
    endtask

    // Drives beat_mem as a fill burst; returns in the response cycle.
    task automatic fill_beats(input int rlast_pos, input int gap_max);
        check("fill_rready", mem_rready, 1);
        for (int i = 0; i < BEATS; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                mem_rvalid = 1'b0;
                mem_rdata  = rand64();
                mem_rlast  = 1'b1;
                tick();
                check("fill_gap_valid", bus_valid, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_mem[i];
            mem_rlast  = (i == rlast_pos);
            tick();
            if (i < BEATS - 1) begin
                check("fill_early_valid", bus_valid, 0);
                check("fill_no_req", mem_req_valid, 0);
            end
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        if (rlast_pos != BEATS - 1) exp_err = 1'b1;
        exp_fill = line_from_beats();
        check("fill_bus_valid", bus_valid, 1);
        check("fill_bus_ready", bus_ready, 0);
        check("fill_err", err, exp_err);
        check_line("fill_line", exp_fill);
    endtask

    task automatic finish_resp();
        tick();
        check("resp_valid_drop", bus_valid, 0);
        check("resp_ready_drop", bus_ready, 0);
        check("resp_no_req", mem_req_valid, 0);
        check_line("resp_hold", exp_fill);
    endtask

    // mode 0: always ready, 1: low on alternate cycles (low first), 2: random.
    task automatic wb_beats(input logic [LINE_BITS-1:0] line, input int mode,
                            input int stop_after, input int bdelay);
        int k;
        int cyc;
        logic rdy;
        k   = 0;
        cyc = 0;
        while (k < BEATS && cyc < 400) begin
            if (stop_after >= 0 && k == stop_after) break;
            check("wb_wvalid", mem_wvalid, 1);
            check($sformatf("wb_wdata_b%0d", k), mem_wdata, line[k*BUS_WIDTH +: BUS_WIDTH]);
            check("wb_wlast", mem_wlast, k == BEATS - 1);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(1, 0));
            mem_wready = rdy;
            tick();
            if (rdy) k++;
            cyc++;
        end
        mem_wready = 1'b0;
        if (stop_after < 0) begin
            check("wb_beats_done", k, BEATS);
            for (int d = 0; d < bdelay; d++) begin
                check("wresp_wvalid", mem_wvalid, 0);
                check("wresp_bus_ready", bus_ready, 0);
                tick();
            end
            mem_bvalid = 1'b1;
            tick();
            mem_bvalid = 1'b0;
            check("wb_bus_ready", bus_ready, 1);
            check("wb_bus_valid", bus_valid, 0);
            check("wb_err", err, exp_err);
            check_line("wb_fill_kept", exp_fill);
            finish_resp();
        end
    endtask

    task automatic random_line(output logic [LINE_BITS-1:0] l);
        for (int i = 0; i < WORDS; i++) l[i*DATA_WIDTH +: DATA_WIDTH] = rand64();
    endtask

    initial begin
        logic [LINE_BITS-1:0]  wline;
        logic [ADDR_WIDTH-1:0] addr;

        n_checks       = 0;
        n_errors       = 0;
        exp_err        = 1'b0;
        exp_fill       = '0;
        reset          = 1'b1;
        command_valid  = 1'b0;
        command_store  = 1'b0;
        command_rready = 1'b1;
        command_addr   = '0;
        data_to_bus    = '0;
        mem_req_ready  = 1'b0;
        mem_wready     = 1'b0;
        mem_bvalid     = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = '0;
        mem_rlast      = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("idle_req_valid", mem_req_valid, 0);

        // Directed fill: beat i carries i+1
        for (int i = 0; i < BEATS; i++) beat_mem[i] = 64'(i + 1);
        send_cmd(1'b0, 64'h1234, '0, 1'b0);
        req_phase(64'h1230, 1'b0, 0);
        fill_beats(BEATS - 1, 0);
        finish_resp();

        // Writeback with wready low on alternate cycles, bvalid 3 cycles late
        for (int i = 0; i < WORDS; i++) wline[i*DATA_WIDTH +: DATA_WIDTH] = 64'(32'hA0 + i);
        addr = rand64();
        send_cmd(1'b1, addr, wline, 1'b0);
        req_phase(line_addr(addr), 1'b1, 0);
        wb_beats(wline, 1, -1, 3);

        // Back-to-back fill then writeback with command_valid held high
        addr = rand64();
        for (int i = 0; i < BEATS; i++) beat_mem[i] = rand64();
        send_cmd(1'b0, addr, '0, 1'b1);
        req_phase(line_addr(addr), 1'b0, 0);
        fill_beats(BEATS - 1, 1);
        random_line(wline);
        command_store = 1'b1;
        data_to_bus   = wline;
        tick();
        check("b2b_idle_no_req", mem_req_valid, 0);
        check("b2b_idle_valid", bus_valid, 0);
        tick();
        command_valid = 1'b0;
        req_phase(line_addr(addr), 1'b1, 0);
        wb_beats(wline, 0, -1, 1);

        // Protocol error: rlast on beat 7
        for (int i = 0; i < BEATS; i++) beat_mem[i] = rand64();
        addr = rand64();
        send_cmd(1'b0, addr, '0, 1'b0);
        req_phase(line_addr(addr), 1'b0, 0);
        fill_beats(7, 0);
        finish_resp();
        check("err_sticky", err, 1);

        // Request backpressure for 10 cycles
        for (int i = 0; i < BEATS; i++) beat_mem[i] = rand64();
        addr = rand64();
        send_cmd(1'b0, addr, '0, 1'b0);
        req_phase(line_addr(addr), 1'b0, 10);
        fill_beats(BEATS - 1, 1);
        finish_resp();

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            addr = rand64();
            if ($urandom_range(1, 0) == 1) begin
                random_line(wline);
                send_cmd(1'b1, addr, wline, 1'b0);
                req_phase(line_addr(addr), 1'b1, int'($urandom_range(3, 0)));
                wb_beats(wline, 2, -1, int'($urandom_range(4, 0)));
            end else begin
                for (int i = 0; i < BEATS; i++) beat_mem[i] = rand64();
                send_cmd(1'b0, addr, '0, 1'b0);
                req_phase(line_addr(addr), 1'b0, int'($urandom_range(3, 0)));
                fill_beats(BEATS - 1, 2);
                finish_resp();
            end
        end

        // Reset in the middle of a writeback after 5 beats
        random_line(wline);
        addr = rand64();
        send_cmd(1'b1, addr, wline, 1'b0);
        req_phase(line_addr(addr), 1'b1, 0);
        wb_beats(wline, 0, 5, 0);
        check("pre_reset_wvalid", mem_wvalid, 1);
        reset = 1'b1;
        tick();
        exp_err  = 1'b0;
        exp_fill = '0;
        check_all_zero("midreset");
        reset = 1'b0;

        // Normal fill after the abandoned burst
        for (int i = 0; i < BEATS; i++) beat_mem[i] = rand64();
        addr = rand64();
        send_cmd(1'b0, addr, '0, 1'b0);
        req_phase(line_addr(addr), 1'b0, 0);
        fill_beats(BEATS - 1, 0);
        finish_resp();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
